a2d_scan: RTL and testbench
===========================

A2D_SCAN -- requirements
Module: a2d_scan

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4095, max cycles WAIT holds for cnv_cmplt before abandoning a channel.
REQ-002 Parameter NUM_CH, default 8, channel count; fixed at 8 in this release.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 scan_go  input  1  one-cycle pulse requesting a single scan of enabled channels.
REQ-006 scan_en  input  1  level; continuous scanning while high.
REQ-007 chnl_mask  input  8  channel enables; bit n enables channel n.
REQ-008 gap_cyc  input  16  idle cycles between continuous scans.
REQ-009 strt_cnv  output  1  one-cycle conversion start to the A2D interface.
REQ-010 chnnl  output  3  channel select to the A2D interface; stable from the strt_cnv cycle until WAIT exits.
REQ-011 cnv_cmplt  input  1  conversion complete from the A2D interface (level).
REQ-012 res  input  12  conversion result, valid while cnv_cmplt is high.
REQ-013 rd_chnl  input  3  readout channel select.
REQ-014 rd_data  output  12  stored result for rd_chnl; combinational read.
REQ-015 res_vld  output  8  per-channel result-valid flags.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 scan_done  output  1  one-cycle pulse when the last enabled channel of a scan finishes.
REQ-018 tmo_err  output  1  sticky flag: some conversion timed out.

Function
REQ-019 FSM states: IDLE, START, WAIT, NEXT, GAP.
REQ-020 IDLE: on (scan_go | scan_en) with chnl_mask != 0, latch chnl_mask into mask_q, set ch to lowest set bit, go to START. With chnl_mask == 0, the request is ignored and the FSM stays in IDLE.
REQ-021 START: drive strt_cnv=1 for exactly one cycle with chnnl=ch, clear the timer, go to WAIT.
REQ-022 WAIT: cnv_cmplt is ignored on the first WAIT cycle (timer==0), because the stale level from the prior conversion may still be present.
REQ-023 WAIT, cnv_cmplt=1 and timer>0: write res to slot ch, set res_vld[ch], go to NEXT.
REQ-024 WAIT, timer==TIMEOUT_CYC without completion: set tmo_err, clear res_vld[ch], leave slot data unchanged, go to NEXT.
REQ-025 Timer: 12-bit, saturating, increments each WAIT cycle.
REQ-026 NEXT: if mask_q has a set bit above ch, ch becomes the next such bit and the FSM goes to START.
REQ-027 NEXT, no higher set bit: pulse scan_done. Go to GAP if scan_en=1, otherwise to IDLE. Channel index never wraps within one scan.
REQ-028 GAP: load counter with gap_cyc on entry, decrement each cycle. At 0, re-evaluate as IDLE does (re-latch chnl_mask). gap_cyc==0 restarts on the next cycle.
REQ-029 scan_en deasserted during GAP: return to IDLE the next cycle.
REQ-030 scan_en deasserted mid-scan: finish the current scan, then go to IDLE.
REQ-031 scan_go while busy: ignored, not queued.
REQ-032 chnl_mask changes mid-scan have no effect until the next latch.
REQ-033 Read and write to the same slot in the same cycle: rd_data returns the old value; the new value appears next cycle.
REQ-034 tmo_err clears only on reset, or when scan_go is accepted in IDLE.

Reset
REQ-035 On rst_n low: state=IDLE, strt_cnv=0, chnnl=0, all result slots=0, res_vld=0, busy=0, scan_done=0, tmo_err=0, counters=0.
REQ-036 Reset mid-WAIT abandons the conversion. Post-reset, cnv_cmplt is not acted on until a new START.

Structure
REQ-037 Package a2d_scan_pkg holds the state enum, NUM_CH, and the default TIMEOUT_CYC and result width (12).
REQ-038 Sub-module a2d_res_regs: an 8x12 result file with valid bits, write port (we, wch, wdata, clr_vld), and combinational read port.

Verification
All scenarios use a stub A2D responder that raises cnv_cmplt 40 cycles after strt_cnv with res=12'hA50|chnnl, held until the next strt_cnv.
REQ-039 mask=8'b0010_0101, scan_go pulse -> strt_cnv on chnnl 0, 2, 5 in order. Slots 0/2/5 = A50/A52/A55. res_vld=8'h25. One scan_done, then IDLE.
REQ-040 mask=0, scan_go -> busy stays 0, no strt_cnv.
REQ-041 scan_en=1, mask=8'h80, gap_cyc=10 -> strt_cnv on chnnl 7 repeats every 40+ack+10+2 cycles. scan_en dropped in GAP -> IDLE within 1 cycle.
REQ-042 Stub suppresses cnv_cmplt on channel 3, TIMEOUT_CYC=100, mask=8'h18 -> tmo_err=1, res_vld[3]=0, slot 4=A54, scan_done asserted.
REQ-043 rst_n low 20 cycles into WAIT -> all outputs at reset values. Next scan_go completes normally.
REQ-044 Stale cnv_cmplt=1 held at START -> not accepted on the first WAIT cycle; result taken only after the stub's new completion.

Source files
------------

// File: rtl/a2d_scan_pkg.sv
// Shared types and constants for the A2D channel scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a2d_scan_pkg;

    localparam int NUM_CH_DFLT      = 8;
    localparam int CH_W             = 3;
    localparam int RES_W            = 12;
    localparam int TMR_W            = 12;
    localparam int TIMEOUT_CYC_DFLT = 4095;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_NEXT  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] low_bit(input logic [NUM_CH_DFLT-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH_DFLT - 1; i >= 0; i--) begin
            if (m[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/a2d_scan_if.sv
// Scanner <-> A2D converter link: start pulse + channel out, level complete + result back.
// Latency: n/a (wires only).
// Backpressure: none; the converter holds cnv_cmplt until the next strt_cnv.
interface a2d_scan_if;
    import a2d_scan_pkg::*;

    logic              strt_cnv;
    logic [CH_W-1:0]   chnnl;
    logic              cnv_cmplt;
    logic [RES_W-1:0]  res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_res_regs.sv
// Per-channel result file with valid bits; one write port, one combinational read port.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none; every write is accepted.
module a2d_res_regs
    import a2d_scan_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    clr_vld,
    input  logic [CH_W-1:0]         wch,
    input  logic [RES_W-1:0]        wdata,
    input  logic [CH_W-1:0]         rch,
    output logic [RES_W-1:0]        rdata,
    output logic [NUM_CH_DFLT-1:0]  vld
);

    logic [RES_W-1:0] mem [NUM_CH_DFLT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH_DFLT; i++) mem[i] <= '0;
            vld <= '0;
        end else if (we) begin
            mem[wch] <= wdata;
            vld[wch] <= 1'b1;
        end else if (clr_vld) begin
            vld[wch] <= 1'b0;
        end
    end

    // Same-cycle read of the slot being written returns the old contents.
    assign rdata = mem[rch];

endmodule

// File: rtl/a2d_scan.sv
// Scans enabled A2D channels in ascending order, once or continuously, storing results per channel.
// Latency: START->WAIT->NEXT per channel, conversion time plus 2 cycles; scan_done in the NEXT cycle.
// Backpressure: scan_go while busy is dropped; cnv_cmplt waits up to TIMEOUT_CYC before the channel is abandoned.
module a2d_scan #(
    parameter int TIMEOUT_CYC = a2d_scan_pkg::TIMEOUT_CYC_DFLT,
    parameter int NUM_CH      = a2d_scan_pkg::NUM_CH_DFLT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           scan_go,
    input  logic                           scan_en,
    input  logic [NUM_CH-1:0]              chnl_mask,
    input  logic [15:0]                    gap_cyc,
    a2d_scan_if.master                     a2d,
    input  logic [a2d_scan_pkg::CH_W-1:0]  rd_chnl,
    output logic [a2d_scan_pkg::RES_W-1:0] rd_data,
    output logic [NUM_CH-1:0]              res_vld,
    output logic                           busy,
    output logic                           scan_done,
    output logic                           tmo_err
);
    import a2d_scan_pkg::*;

    localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TIMEOUT_CYC);

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [NUM_CH-1:0]  mask_q;
    logic [NUM_CH-1:0]  above;
    logic [TMR_W-1:0]   timer;
    logic [15:0]        gap_cnt;
    logic               launch_ok;
    logic               res_we;
    logic               res_clr;

    assign launch_ok = |chnl_mask;
    // Enabled channels strictly above the current one; empty once ch is the top enabled bit.
    assign above     = mask_q & ~((NUM_CH'(2) << ch) - NUM_CH'(1));

    // timer==0 guard skips a complete level left over from the previous conversion.
    assign res_we  = (state == ST_WAIT) && a2d.cnv_cmplt && (timer != '0);
    assign res_clr = (state == ST_WAIT) && !res_we && (timer == TMO_LIM);

    assign a2d.strt_cnv = (state == ST_START);
    assign a2d.chnnl    = ch;
    assign busy         = (state != ST_IDLE);
    assign scan_done    = (state == ST_NEXT) && (above == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ch      <= '0;
            mask_q  <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((scan_go || scan_en) && launch_ok) begin
                        mask_q <= chnl_mask;
                        ch     <= low_bit(chnl_mask);
                        state  <= ST_START;
                        if (scan_go) tmo_err <= 1'b0;
                    end
                end
                ST_START: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (res_we) begin
                        state <= ST_NEXT;
                    end else if (timer == TMO_LIM) begin
                        tmo_err <= 1'b1;
                        state   <= ST_NEXT;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (above != '0) begin
                        ch    <= low_bit(above);
                        state <= ST_START;
                    end else begin
                        gap_cnt <= gap_cyc;
                        state   <= scan_en ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (!scan_en) begin
                        state <= ST_IDLE;
                    end else if (gap_cnt == '0) begin
                        if (launch_ok) begin
                            mask_q <= chnl_mask;
                            ch     <= low_bit(chnl_mask);
                            state  <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a2d_res_regs u_res_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (res_we),
        .clr_vld (res_clr),
        .wch     (ch),
        .wdata   (a2d.res),
        .rch     (rd_chnl),
        .rdata   (rd_data),
        .vld     (res_vld)
    );

endmodule

// File: tb/tb_a2d_scan.sv
// Directed bench for a2d_scan with a behavioural A2D responder (complete 40 cycles after start).
module tb_a2d_scan;

    logic        clk;
    logic        rst_n;
    logic        scan_go;
    logic        scan_en;
    logic [7:0]  chnl_mask;
    logic [15:0] gap_cyc;
    logic [2:0]  rd_chnl;
    logic [11:0] rd_data;
    logic [7:0]  res_vld;
    logic        busy;
    logic        scan_done;
    logic        tmo_err;

    a2d_scan_if a2d_if ();

    a2d_scan #(.TIMEOUT_CYC(100), .NUM_CH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_go   (scan_go),
        .scan_en   (scan_en),
        .chnl_mask (chnl_mask),
        .gap_cyc   (gap_cyc),
        .a2d       (a2d_if),
        .rd_chnl   (rd_chnl),
        .rd_data   (rd_data),
        .res_vld   (res_vld),
        .busy      (busy),
        .scan_done (scan_done),
        .tmo_err   (tmo_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         done_cnt = 0;
    logic [2:0] st_ch[$];
    int         st_t[$];
    bit         supp_en    = 0;
    logic [2:0] supp_ch    = 3'd0;
    bit         stale_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: raises complete 40 cycles after start, holds it until the next start.
    initial begin
        int         age;
        bit         armed;
        bit         stale_pend;
        logic [2:0] cur_ch;
        age = 0; armed = 0; stale_pend = 0; cur_ch = 3'd0;
        a2d_if.cnv_cmplt = 1'b0;
        a2d_if.res       = 12'h000;
        forever begin
            @(negedge clk);
            if (a2d_if.strt_cnv) begin
                age = 0; armed = 1; cur_ch = a2d_if.chnnl;
                if (stale_mode) begin
                    a2d_if.cnv_cmplt = 1'b1; a2d_if.res = 12'h111; stale_pend = 1;
                end else begin
                    a2d_if.cnv_cmplt = 1'b0;
                end
            end else if (armed) begin
                age++;
                if (stale_pend) begin
                    a2d_if.cnv_cmplt = 1'b0; stale_pend = 0;
                end
                if (age == 40) begin
                    armed = 0;
                    if (!(supp_en && cur_ch == supp_ch)) begin
                        a2d_if.cnv_cmplt = 1'b1;
                        a2d_if.res = 12'hA50 | {9'd0, cur_ch};
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (a2d_if.strt_cnv) begin
            st_ch.push_back(a2d_if.chnnl);
            st_t.push_back(cyc);
        end
        if (scan_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic pulse_go(input logic [7:0] m);
        @(negedge clk);
        chnl_mask = m; scan_go = 1'b1;
        @(negedge clk);
        scan_go = 1'b0;
    endtask

    task automatic read_slot(input logic [2:0] c, output logic [11:0] d);
        rd_chnl = c;
        #1;
        d = rd_data;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        logic [11:0] d;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_tests++; if (a2d_if.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL reset_strt_cnv: got %0h want 0", a2d_if.strt_cnv); end
        n_tests++; if (a2d_if.chnnl !== 3'd0) begin n_fail++; $display("FAIL reset_chnnl: got %0h want 0", a2d_if.chnnl); end
        n_tests++; if (res_vld !== 8'h00) begin n_fail++; $display("FAIL reset_res_vld: got %0h want 00", res_vld); end
        n_tests++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done: got %0h want 0", scan_done); end
        n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo_err: got %0h want 0", tmo_err); end
        read_slot(3'd0, d);
        n_tests++; if (d !== 12'h000) begin n_fail++; $display("FAIL reset_slot0: got %0h want 000", d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_scan;
        bit          ok;
        logic [11:0] d;
        logic [2:0]  exp_ch [3];
        exp_ch = '{3'd0, 3'd2, 3'd5};
        st_ch.delete(); st_t.delete(); done_cnt = 0;
        pulse_go(8'h25);
        repeat (10) @(negedge clk);
        chnl_mask = 8'hFF; scan_go = 1'b1;
        @(negedge clk);
        scan_go = 1'b0;
        wait_idle(600, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_idle: scan did not finish"); end
        n_tests++; if (st_ch.size() != 3) begin n_fail++; $display("FAIL single_start_count: got %0d want 3", st_ch.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (st_ch.size() <= i || st_ch[i] !== exp_ch[i]) begin
                n_fail++; $display("FAIL single_order[%0d]: want ch %0d", i, exp_ch[i]);
            end
            read_slot(exp_ch[i], d);
            n_tests++; if (d !== (12'hA50 | {9'd0, exp_ch[i]})) begin n_fail++; $display("FAIL single_slot%0d: got %0h want %0h", exp_ch[i], d, 12'hA50 | {9'd0, exp_ch[i]}); end
        end
        n_tests++; if (res_vld !== 8'h25) begin n_fail++; $display("FAIL single_res_vld: got %0h want 25", res_vld); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL single_tmo_err: got %0h want 0", tmo_err); end
    endtask

    task automatic test_zero_mask;
        bit saw_busy;
        st_ch.delete();
        saw_busy = 0;
        pulse_go(8'h00);
        repeat (20) begin
            @(negedge clk); #1;
            if (busy) saw_busy = 1;
        end
        n_tests++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL zero_mask_busy: got 1 want 0"); end
        n_tests++; if (st_ch.size() != 0) begin n_fail++; $display("FAIL zero_mask_starts: got %0d want 0", st_ch.size()); end
    endtask

    task automatic test_continuous;
        bit          ok;
        int          n;
        logic [11:0] d;
        @(negedge clk);
        st_ch.delete(); st_t.delete();
        gap_cyc = 16'd10; chnl_mask = 8'h80; scan_en = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (st_ch.size() >= 3) begin ok = 1; break; end
        end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_three_starts: got %0d starts want 3", st_ch.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (st_ch.size() <= i || st_ch[i] !== 3'd7) begin n_fail++; $display("FAIL cont_ch[%0d]: want ch 7", i); end
        end
        if (ok) begin
            n_tests++; if (st_t[1] - st_t[0] != 53) begin n_fail++; $display("FAIL cont_period1: got %0d want 53", st_t[1] - st_t[0]); end
            n_tests++; if (st_t[2] - st_t[1] != 53) begin n_fail++; $display("FAIL cont_period2: got %0d want 53", st_t[2] - st_t[1]); end
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (scan_done) begin ok = 1; break; end
        end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_scan_done: not seen"); end
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_gap_busy: got %0h want 1", busy); end
        scan_en = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_gap_exit: got %0h want 0", busy); end
        n = st_ch.size();
        repeat (70) @(negedge clk);
        n_tests++; if (st_ch.size() != n) begin n_fail++; $display("FAIL cont_no_restart: got %0d starts want %0d", st_ch.size(), n); end
        n_tests++; if (res_vld !== 8'hA5) begin n_fail++; $display("FAIL cont_res_vld: got %0h want a5", res_vld); end
        read_slot(3'd7, d);
        n_tests++; if (d !== 12'hA57) begin n_fail++; $display("FAIL cont_slot7: got %0h want a57", d); end
    endtask

    task automatic test_timeout;
        bit          ok;
        logic [11:0] d;
        supp_en = 0;
        pulse_go(8'h08);
        wait_idle(600, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_pre_idle: scan did not finish"); end
        n_tests++; if (res_vld !== 8'hAD) begin n_fail++; $display("FAIL tmo_pre_res_vld: got %0h want ad", res_vld); end
        st_ch.delete(); st_t.delete(); done_cnt = 0;
        supp_en = 1; supp_ch = 3'd3;
        pulse_go(8'h18);
        wait_idle(600, ok);
        supp_en = 0;
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_idle: scan did not finish"); end
        n_tests++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %0h want 1", tmo_err); end
        n_tests++; if (res_vld !== 8'hB5) begin n_fail++; $display("FAIL tmo_res_vld: got %0h want b5", res_vld); end
        read_slot(3'd3, d);
        n_tests++; if (d !== 12'hA53) begin n_fail++; $display("FAIL tmo_slot3_kept: got %0h want a53", d); end
        read_slot(3'd4, d);
        n_tests++; if (d !== 12'hA54) begin n_fail++; $display("FAIL tmo_slot4: got %0h want a54", d); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
        n_tests++; if (st_t.size() < 2 || st_t[1] - st_t[0] != 103) begin n_fail++; $display("FAIL tmo_duration: want 103 cycles between starts"); end
    endtask

    task automatic test_reset_mid_wait;
        bit          ok;
        bit          saw_busy;
        logic [11:0] d;
        st_ch.delete();
        @(negedge clk);
        chnl_mask = 8'h02; scan_en = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (st_ch.size() > 0) begin ok = 1; break; end
        end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_wait_start: no strt_cnv"); end
        repeat (20) @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_busy: got %0h want 1", busy); end
        n_tests++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL rst_tmo_sticky: got %0h want 1", tmo_err); end
        rst_n = 1'b0; scan_en = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_tests++; if (a2d_if.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rst_strt_cnv: got %0h want 0", a2d_if.strt_cnv); end
        n_tests++; if (a2d_if.chnnl !== 3'd0) begin n_fail++; $display("FAIL rst_chnnl: got %0h want 0", a2d_if.chnnl); end
        n_tests++; if (res_vld !== 8'h00) begin n_fail++; $display("FAIL rst_res_vld: got %0h want 00", res_vld); end
        n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo_err: got %0h want 0", tmo_err); end
        n_tests++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_scan_done: got %0h want 0", scan_done); end
        read_slot(3'd4, d);
        n_tests++; if (d !== 12'h000) begin n_fail++; $display("FAIL rst_slot4: got %0h want 000", d); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw_busy = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (busy) saw_busy = 1;
        end
        n_tests++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL rst_post_idle: busy seen after reset"); end
        n_tests++; if (res_vld !== 8'h00) begin n_fail++; $display("FAIL rst_post_res_vld: got %0h want 00", res_vld); end
        rd_chnl = 3'd1;
        pulse_go(8'h02);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (a2d_if.cnv_cmplt) begin ok = 1; break; end
        end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rw_cmplt_seen: no completion"); end
        n_tests++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL rw_same_cycle_old: got %0h want 000", rd_data); end
        @(negedge clk); #1;
        n_tests++; if (rd_data !== 12'hA51) begin n_fail++; $display("FAIL rw_next_cycle_new: got %0h want a51", rd_data); end
        wait_idle(200, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_rescan_idle: scan did not finish"); end
        n_tests++; if (res_vld !== 8'h02) begin n_fail++; $display("FAIL rst_rescan_res_vld: got %0h want 02", res_vld); end
    endtask

    task automatic test_stale;
        bit          ok;
        logic [11:0] d;
        stale_mode = 1;
        pulse_go(8'h40);
        wait_idle(300, ok);
        stale_mode = 0;
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stale_idle: scan did not finish"); end
        read_slot(3'd6, d);
        n_tests++; if (d !== 12'hA56) begin n_fail++; $display("FAIL stale_slot6: got %0h want a56", d); end
        n_tests++; if (res_vld !== 8'h42) begin n_fail++; $display("FAIL stale_res_vld: got %0h want 42", res_vld); end
    endtask

    initial begin
        rst_n = 1'b0; scan_go = 1'b0; scan_en = 1'b0;
        chnl_mask = 8'h00; gap_cyc = 16'd0; rd_chnl = 3'd0;
        test_reset();
        test_single_scan();
        test_zero_mask();
        test_continuous();
        test_timeout();
        test_reset_mid_wait();
        test_stale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
